// File: rtl/cordic_sequencer.sv
// cordic_sequencer: quadrant-folding handshake sequencer around a first-quadrant CORDIC core.
// Optional timeout watchdog enabled by defining CORDIC_SEQ_TIMEOUT_EN.
module cordic_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] phase_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        cordic_start,
  output logic [15:0] cordic_angle,
  input  logic        cordic_recived,
  input  logic        cordic_valid,
  input  logic [15:0] cordic_cos,
  input  logic [15:0] cordic_sin,
  output logic [15:0] cos_out,
  output logic [15:0] sin_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, RELEASE, OUT} state_t;
  state_t state;
  logic [1:0] q;
  logic [15:0] cap_c, cap_s;
  logic got, tout;
  logic signed [16:0] cx, sx;
  logic signed [15:0] c, s, mc, ms;
  // 0x8000 from the core means +1.0, so it is widened as unsigned before halving
  always_comb begin
    cx = (cap_c == 16'h8000) ? 17'sd32768 : {cap_c[15], cap_c};
    sx = (cap_s == 16'h8000) ? 17'sd32768 : {cap_s[15], cap_s};
    c  = cx[16:1];
    s  = sx[16:1];
    mc = (q == 2'd0) ? c : (q == 2'd1) ? -s : (q == 2'd2) ? -c : s;
    ms = (q == 2'd0) ? s : (q == 2'd1) ? c : (q == 2'd2) ? -s : -c;
  end
`ifdef CORDIC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic err_q;
  assign tout = (state == REQ || state == WAIT) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign err  = err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt  <= (state == REQ || state == WAIT) && !tout ? tcnt + 1'b1 : '0;
      err_q <= err_q | tout;
    end
`else
  // never fires; keeps the parameter referenced when the watchdog is compiled out
  assign tout = TIMEOUT_CYCLES < 0;
  assign err  = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      cordic_start <= 1'b0;
      cordic_angle <= '0;
      cos_out      <= '0;
      sin_out      <= '0;
      out_valid    <= 1'b0;
      q            <= '0;
      cap_c        <= '0;
      cap_s        <= '0;
      got          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          q            <= phase_in[15:14];
          cordic_angle <= {1'b0, phase_in[13:0], 1'b0};
          in_ready     <= 1'b0;
          cordic_start <= 1'b1;
          got          <= 1'b0;
          state        <= REQ;
        end
        REQ: if (tout) begin
          cap_c        <= '0;
          cap_s        <= '0;
          cordic_start <= 1'b0;
          state        <= RELEASE;
        end else if (cordic_recived || cordic_valid) begin
          // a result already present here is kept so a short valid pulse is not lost
          if (cordic_valid) begin
            cap_c <= cordic_cos;
            cap_s <= cordic_sin;
            got   <= 1'b1;
          end
          state <= WAIT;
        end
        WAIT: if (tout) begin
          cap_c        <= '0;
          cap_s        <= '0;
          cordic_start <= 1'b0;
          state        <= RELEASE;
        end else if (cordic_valid || got) begin
          if (cordic_valid) begin
            cap_c <= cordic_cos;
            cap_s <= cordic_sin;
          end
          cordic_start <= 1'b0;
          state        <= RELEASE;
        end
        RELEASE: if (!cordic_valid) begin
          cos_out   <= mc;
          sin_out   <= ms;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cordic_sequencer.sv
// tb_cordic_sequencer: table-driven scoreboard bench with a behavioural CORDIC core model.
module tb_cordic_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] phase_in = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, cordic_start, out_valid, err;
  logic [15:0] cordic_angle, cos_out, sin_out;
  logic rcv, cv;
  logic [15:0] ccos, csin;
  logic core_en = 1'b1;
  int core_lat = 2;
  logic [15:0] core_c = '0, core_s = '0;
  int cnt;
  int vectors = 0, miscompares = 0;
  typedef struct { logic [15:0] ph, cc, cs; int lat; logic [15:0] ang, ec, es; } vec_t;
  typedef struct { logic [15:0] c, s; } exp_t;
  vec_t tv[9];
  exp_t sb[$];
  exp_t e;

  cordic_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .phase_in(phase_in), .in_valid(in_valid), .in_ready(in_ready),
    .cordic_start(cordic_start), .cordic_angle(cordic_angle), .cordic_recived(rcv),
    .cordic_valid(cv), .cordic_cos(ccos), .cordic_sin(csin), .cos_out(cos_out),
    .sin_out(sin_out), .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  // core: acknowledges a cycle after start, result core_lat edges after start, held until start drops
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rcv <= 1'b0; cv <= 1'b0; cnt <= 0; ccos <= '0; csin <= '0;
    end else begin
      rcv <= cordic_start & core_en;
      if (!cordic_start) begin
        cv <= 1'b0; cnt <= 0;
      end else if (core_en && !cv) begin
        if (cnt == core_lat - 1) begin
          cv <= 1'b1; ccos <= core_c; csin <= core_s;
        end else cnt <= cnt + 1;
      end
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_accept(input vec_t v, input logic [15:0] ec, input logic [15:0] es);
    core_lat = v.lat; core_c = v.cc; core_s = v.cs;
    chk("in_ready_idle", 16'(in_ready), 16'h1);
    phase_in = v.ph; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sb.push_back('{ec, es});
    chk("angle", cordic_angle, v.ang);
    chk("start_req", 16'(cordic_start), 16'h1);
    chk("in_ready_busy", 16'(in_ready), 16'h0);
  endtask

  task automatic wait_out(input int bound, output int n);
    n = 0;
    while (!out_valid && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic take_out();
    chk("out_valid", 16'(out_valid), 16'h1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("cos_out", cos_out, e.c);
      chk("sin_out", sin_out, e.s);
    end else chk("scoreboard_empty", 16'h1, 16'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", 16'(out_valid), 16'h0);
    chk("in_ready_back", 16'(in_ready), 16'h1);
    chk("cos_hold", cos_out, e.c);
    chk("sin_hold", sin_out, e.s);
  endtask

  initial begin
    int n;
    tv[0] = '{16'h0000, 16'h8000, 16'h0000, 2, 16'h0000, 16'h4000, 16'h0000};
    tv[1] = '{16'h2000, 16'h5A82, 16'h5A82, 3, 16'h4000, 16'h2D41, 16'h2D41};
    tv[2] = '{16'h4000, 16'h8000, 16'h0000, 4, 16'h0000, 16'h0000, 16'h4000};
    tv[3] = '{16'hA000, 16'h5A82, 16'h5A82, 2, 16'h4000, 16'hD2BF, 16'hD2BF};
    tv[4] = '{16'hE000, 16'h5A82, 16'h5A82, 5, 16'h4000, 16'h2D41, 16'hD2BF};
    tv[5] = '{16'h6000, 16'h5A82, 16'h5A82, 2, 16'h4000, 16'hD2BF, 16'h2D41};
    tv[6] = '{16'h3FFF, 16'h0000, 16'h8000, 3, 16'h7FFE, 16'h0000, 16'h4000};
    tv[7] = '{16'h8000, 16'hC000, 16'h7FFE, 6, 16'h0000, 16'h2000, 16'hC001};
    tv[8] = '{16'hFFFF, 16'h8000, 16'h8000, 2, 16'h7FFE, 16'h4000, 16'hC000};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", 16'(cordic_start), 16'h0);
    chk("rst_angle", cordic_angle, 16'h0);
    chk("rst_cos", cos_out, 16'h0);
    chk("rst_sin", sin_out, 16'h0);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    for (int i = 0; i < 9; i++) begin
      do_accept(tv[i], tv[i].ec, tv[i].es);
      wait_out(200, n);
      chk("latency", 16'(n), 16'(tv[i].lat + 3));
      take_out();
    end
    // downstream stall: outputs frozen, extra phases ignored
    do_accept(tv[1], tv[1].ec, tv[1].es);
    wait_out(200, n);
    for (int i = 0; i < 10; i++) begin
      phase_in = 16'h1234 + 16'(i); in_valid = 1'b1;
      tick();
      chk("stall_valid", 16'(out_valid), 16'h1);
      chk("stall_cos", cos_out, 16'h2D41);
      chk("stall_sin", sin_out, 16'h2D41);
      chk("stall_in_ready", 16'(in_ready), 16'h0);
      chk("stall_angle", cordic_angle, 16'h4000);
    end
    in_valid = 1'b0;
    take_out();
    chk("no_ghost_start", 16'(cordic_start), 16'h0);
    do_accept(tv[3], tv[3].ec, tv[3].es);
    wait_out(200, n);
    chk("latency_after_stall", 16'(n), 16'(tv[3].lat + 3));
    take_out();
    // reset mid-transaction drops start without waiting for a clock
    core_en = 1'b0;
    do_accept(tv[4], tv[4].ec, tv[4].es);
    repeat (3) tick();
    chk("busy_start", 16'(cordic_start), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_start", 16'(cordic_start), 16'h0);
    chk("async_angle", cordic_angle, 16'h0);
    chk("async_cos", cos_out, 16'h0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 16'(in_ready), 16'h1);
`ifdef CORDIC_SEQ_TIMEOUT_EN
    do_accept(tv[1], 16'h0000, 16'h0000);
    repeat (63) tick();
    chk("err_before_timeout", 16'(err), 16'h0);
    tick();
    chk("err_at_timeout", 16'(err), 16'h1);
    chk("timeout_start", 16'(cordic_start), 16'h0);
    wait_out(20, n);
    take_out();
    repeat (5) tick();
    chk("err_sticky", 16'(err), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("err_cleared", 16'(err), 16'h0);
    tick();
    rst_n = 1'b1;
    tick();
`else
    do_accept(tv[1], tv[1].ec, tv[1].es);
    repeat (80) tick();
    chk("no_timeout_err", 16'(err), 16'h0);
    chk("no_timeout_valid", 16'(out_valid), 16'h0);
    chk("still_waiting", 16'(cordic_start), 16'h1);
    core_en = 1'b1;
    wait_out(200, n);
    take_out();
`endif
    core_en = 1'b1;
    do_accept(tv[7], tv[7].ec, tv[7].es);
    wait_out(200, n);
    chk("latency_final", 16'(n), 16'(tv[7].lat + 3));
    take_out();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cordic_sequencer.md
CORDIC_SEQUENCER -- requirements
Module: cordic_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, maximum cycles to wait for cordic_valid after start assertion.
REQ-002 Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-003 Ports:
- phase_in  in  16  unsigned full-circle angle, 0x0000..0xFFFF = 0..360 deg.
- in_valid  in  1  phase_in valid.
- in_ready  out  1  block can accept a phase.
REQ-004 Ports:
- cordic_start  out  1  start to cordic core.
- cordic_angle  out  16  first-quadrant angle to core.
- cordic_recived  in  1  core acknowledge.
- cordic_valid  in  1  core result valid.
- cordic_cos  in  16  core cosine.
- cordic_sin  in  16  core sine.
REQ-005 Ports:
- cos_out  out  16  signed Q2.14 cosine, 0x4000 = +1.0.
- sin_out  out  16  signed Q2.14 sine, 0x4000 = +1.0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- err  out  1  sticky timeout flag.

Function
REQ-006 The state machine SHALL have five states: IDLE, REQ, WAIT, RELEASE, OUT.
REQ-007 IDLE: in_ready = 1; on in_valid, latch q = phase_in[15:14] and cordic_angle = {1'b0, phase_in[13:0], 1'b0}, then go to REQ.
REQ-008 REQ: cordic_start = 1; go to WAIT on cordic_recived or cordic_valid, whichever comes first.
REQ-009 WAIT: cordic_start stays 1; on cordic_valid, capture cordic_cos/cordic_sin and go to RELEASE.
REQ-010 RELEASE: cordic_start = 0; wait until cordic_valid = 0, then go to OUT.
REQ-011 OUT: out_valid = 1 with outputs stable; on out_ready, go to IDLE.
- The accept cycle SHALL NOT also accept a new phase.
REQ-012 Magnitude conversion of each captured value x: 0x8000 maps to +32768, otherwise sign-extend; then arithmetic shift right by 1 to form Q2.14.
REQ-013 Quadrant mapping from converted values (c, s):
- q=0: (c, s).
- q=1: (-s, c).
- q=2: (-c, -s).
- q=3: (s, -c).
REQ-014 The quadrant mapping SHALL be registered into cos_out/sin_out on entry to OUT.
REQ-015 Latency from phase accept to out_valid SHALL be the core latency + 3 cycles.
REQ-016 cos_out/sin_out SHALL hold their last value outside OUT.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 in_valid outside IDLE SHALL be ignored, with no data change.

Reset
REQ-019 rst_n low SHALL immediately force:
- state = IDLE.
- cordic_start = 0.
- cordic_angle = 0.
- cos_out = 0, sin_out = 0.
- out_valid = 0.
- err = 0.
- timeout counter = 0.
- in_ready = 1 after release.
REQ-020 Reset mid-operation SHALL abandon the transaction; the core sees cordic_start drop asynchronously.

Configuration
REQ-021 With macro CORDIC_SEQ_TIMEOUT_EN defined, a counter SHALL count cycles spent in REQ or WAIT.
- Reaching TIMEOUT_CYCLES sets err = 1 (sticky until reset), drops cordic_start, and goes to RELEASE.
- The resulting OUT SHALL present cos_out = 0, sin_out = 0.
REQ-022 Without CORDIC_SEQ_TIMEOUT_EN: no counter is present, err is tied 0, and WAIT waits indefinitely.

Verification
REQ-023 phase_in 0x0000 with core model returning cos 0x8000, sin 0x0000 -> cos_out 0x4000, sin_out 0x0000; cordic_angle 0x0000.
REQ-024 phase_in 0x2000 -> cordic_angle 0x4000; core returns 0x5A82/0x5A82 -> cos_out 0x2D41, sin_out 0x2D41.
REQ-025 phase_in 0x4000 (q=1, residual 0), core 0x8000/0x0000 -> cos_out 0x0000, sin_out 0x4000.
REQ-026 phase_in 0xA000 (q=2), core 0x5A82/0x5A82 -> cos_out 0xD2BF, sin_out 0xD2BF.
REQ-027 out_ready held low 10 cycles after out_valid -> outputs stable, in_ready 0, second in_valid ignored; accept on release.
REQ-028 CORDIC_SEQ_TIMEOUT_EN defined, core never asserts valid -> err 1 after 64 cycles in REQ/WAIT, out_valid with 0/0, err persists until rst_n low.
